dm_access_ctrl: RTL

// - Sequencer/arbiter for the byte-wide data memory (1 KiB, big-endian: MSB at lowest byte address).
// - Shares it between the pipeline MEM stage (cpu_*) and the debug/loader port (dbg_*).
// - Each 64-bit access runs as 8 byte beats. Fixed latency of 10 cycles. cpu_stall freezes the pipeline meanwhile.

---
 rtl/dm_pkg.sv | 25 ++
 rtl/dm_rr_arb.sv | 35 +++
 rtl/dm_access_ctrl.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/dm_pkg.sv
// Shared types and helpers for the data-memory access sequencer.
// Big-endian byte order: beat 0 carries the most significant byte of the word.
package dm_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        LAST = 2'd2,
        DONE = 2'd3
    } state_t;

    typedef enum logic {
        REQ_CPU = 1'b0,
        REQ_DBG = 1'b1
    } req_id_t;

    localparam int BEATS  = 8;
    localparam int BEAT_W = $clog2(BEATS);

    // Byte k of a doubleword in big-endian order (k = 0 is bits 63:56).
    function automatic logic [7:0] beat_byte(input logic [63:0] word, input logic [BEAT_W-1:0] k);
        return word[(BEATS - 1 - int'(k)) * 8 +: 8];
    endfunction

endpackage

// File: rtl/dm_rr_arb.sv
// Two-way round-robin arbiter between the CPU (bit 0) and debug (bit 1) ports.
// last_grant doubles as the identity of the owner for the transfer in flight.
module dm_rr_arb
    import dm_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] i_req,
    input  logic       i_grant_en,
    output logic [1:0] o_gnt,
    output logic       o_last_grant
);

    logic r_last_grant;

    always_comb begin
        o_gnt = 2'b00;
        if (i_grant_en) begin
            if (i_req == 2'b11)
                o_gnt = (r_last_grant == REQ_DBG) ? 2'b01 : 2'b10;
            else
                o_gnt = i_req;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_last_grant <= REQ_DBG;
        else if (|o_gnt)
            r_last_grant <= o_gnt[1] ? REQ_DBG : REQ_CPU;
    end

    assign o_last_grant = r_last_grant;

endmodule

// File: rtl/dm_access_ctrl.sv
// Sequences 64-bit CPU/debug accesses into eight byte beats on a byte-wide
// synchronous memory, with round-robin sharing and a fixed 10-cycle latency.
module dm_access_ctrl
    import dm_pkg::*;
#(
    parameter int ADDR_W = 10
)
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_cpu_req,
    input  logic              i_cpu_we,
    input  logic [63:0]       i_cpu_addr,
    input  logic [63:0]       i_cpu_wdata,
    output logic [63:0]       o_cpu_rdata,
    output logic              o_cpu_done,
    output logic              o_cpu_err,
    output logic              o_cpu_stall,
    input  logic              i_dbg_req,
    input  logic              i_dbg_we,
    input  logic [63:0]       i_dbg_addr,
    input  logic [63:0]       i_dbg_wdata,
    output logic [63:0]       o_dbg_rdata,
    output logic              o_dbg_done,
    output logic              o_dbg_err,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic              o_mem_re,
    output logic              o_mem_we,
    output logic [7:0]        o_mem_wdata,
    input  logic [7:0]        i_mem_rdata
);

    localparam int DW_DEPTH = 2 ** (ADDR_W - 3);
    localparam int DWA_W    = ADDR_W - 3;

    state_t            r_state;
    state_t            w_next_state;
    logic [BEAT_W-1:0] r_beat;
    logic              r_we;
    logic              r_err;
    logic [DWA_W-1:0]  r_addr;
    logic [63:0]       r_wdata;
    logic [63:0]       r_shift;
    logic [63:0]       r_cpu_rdata;
    logic [63:0]       r_dbg_rdata;

    logic [1:0]        w_req;
    logic [1:0]        w_gnt;
    logic              w_grant_en;
    logic              w_granted;
    logic              w_sel_dbg;
    logic              w_sel_we;
    logic [63:0]       w_sel_addr;
    logic [63:0]       w_sel_wdata;
    logic              w_in_range;
    logic              w_owner;
    logic              w_capture;
    logic              w_last_beat;

    assign w_req      = {i_dbg_req, i_cpu_req};
    assign w_grant_en = (r_state == IDLE);

    dm_rr_arb u_arb (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_req        (w_req),
        .i_grant_en   (w_grant_en),
        .o_gnt        (w_gnt),
        .o_last_grant (w_owner)
    );

    assign w_granted   = |w_gnt;
    assign w_sel_dbg   = w_gnt[1];
    assign w_sel_we    = w_sel_dbg ? i_dbg_we    : i_cpu_we;
    assign w_sel_addr  = w_sel_dbg ? i_dbg_addr  : i_cpu_addr;
    assign w_sel_wdata = w_sel_dbg ? i_dbg_wdata : i_cpu_wdata;
    assign w_in_range  = (w_sel_addr < 64'(DW_DEPTH));
    assign w_last_beat = (r_beat == BEAT_W'(BEATS - 1));

    // Read data lags its strobe by one cycle, so beat k-1 is captured during beat k.
    assign w_capture = !r_we && (((r_state == XFER) && (r_beat != '0)) || (r_state == LAST));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= IDLE;
        else
            r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_granted)
                    w_next_state = w_in_range ? XFER : DONE;
            end
            XFER: begin
                if (w_last_beat)
                    w_next_state = LAST;
            end
            LAST:    w_next_state = DONE;
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Strobes decode straight from registered state so an async reset drops them at once.
    always_comb begin
        o_mem_addr  = '0;
        o_mem_re    = 1'b0;
        o_mem_we    = 1'b0;
        o_mem_wdata = '0;
        o_cpu_done  = 1'b0;
        o_dbg_done  = 1'b0;
        o_cpu_err   = 1'b0;
        o_dbg_err   = 1'b0;
        case (r_state)
            XFER: begin
                o_mem_addr = {r_addr, r_beat};
                o_mem_re   = !r_we;
                o_mem_we   = r_we;
                if (r_we)
                    o_mem_wdata = beat_byte(r_wdata, r_beat);
            end
            DONE: begin
                o_cpu_done = (w_owner == REQ_CPU);
                o_dbg_done = (w_owner == REQ_DBG);
                o_cpu_err  = (w_owner == REQ_CPU) && r_err;
                o_dbg_err  = (w_owner == REQ_DBG) && r_err;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_beat  <= '0;
            r_we    <= 1'b0;
            r_err   <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_beat <= '0;
                    if (w_granted) begin
                        r_we    <= w_sel_we;
                        r_addr  <= w_sel_addr[DWA_W-1:0];
                        r_wdata <= w_sel_wdata;
                        r_err   <= !w_in_range;
                    end
                end
                XFER:    r_beat <= r_beat + 1'b1;
                default: ;
            endcase
        end
    end

    // Each port's rdata only changes on its own load completion or out-of-range access.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift     <= '0;
            r_cpu_rdata <= '0;
            r_dbg_rdata <= '0;
        end else begin
            if (w_capture)
                r_shift <= {r_shift[55:0], i_mem_rdata};
            if ((r_state == LAST) && !r_we) begin
                if (w_owner == REQ_DBG)
                    r_dbg_rdata <= {r_shift[55:0], i_mem_rdata};
                else
                    r_cpu_rdata <= {r_shift[55:0], i_mem_rdata};
            end
            if (w_granted && !w_in_range) begin
                if (w_sel_dbg)
                    r_dbg_rdata <= '0;
                else
                    r_cpu_rdata <= '0;
            end
        end
    end

    assign o_cpu_rdata = r_cpu_rdata;
    assign o_dbg_rdata = r_dbg_rdata;
    assign o_cpu_stall = i_cpu_req & ~o_cpu_done;

endmodule
